uram_wght_stream: RTL and testbench
===================================

Name: uram_wght_stream

Overview:
Parametrised successor of the single-port-pair URAM weight store. It keeps an independent write port, now with byte enables, and adds a burst read engine. The engine accepts a (start address, length) command and streams weights out over a valid/ready interface with full backpressure. Neuron-layer cores use it to pull contiguous weight rows without per-word address management.

Parameters:
DATA_W, 64, weight word width in bits; multiple of 8.
RAM_DEPTH, 10485, number of words.
ADDR_W, $clog2(RAM_DEPTH), address width.
RD_LAT, 2, URAM read pipeline stages (1..4); the array read register is stage 1.
LEN_W, 16, burst length width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wren  in  1  write enable
wraddr  in  ADDR_W  write address
wrdat  in  DATA_W (signed)  write data
wrbe  in  DATA_W/8  byte enables; bit i covers wrdat[8i+7:8i]
cmd_valid  in  1  burst command valid
cmd_ready  out  1  engine can accept a command
cmd_addr  in  ADDR_W  burst start address
cmd_len  in  LEN_W  burst word count
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts word
out_data  out  DATA_W (signed)  streamed weight word
out_last  out  1  final word of burst, qualified by out_valid
busy  out  1  burst in progress

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Write port:
  - On wren, bytes with wrbe[i]=1 are written at wraddr; other bytes are unchanged.
  - wraddr >= RAM_DEPTH: write is dropped.
  - The write port is fully independent of burst state.
- Read/write collision at the same address in the same cycle: the read returns the old data (read-first).
- Reset:
  - cmd_ready=0 during the rst cycle, 1 from the first cycle after.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - In-flight reads and buffered words are discarded. Memory contents are not cleared.
  - rst mid-burst aborts the burst silently.
- FSM IDLE -> RUN -> IDLE:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr/len. len=0 is accepted and stays in IDLE with no output. len>0 goes to RUN, busy=1.
  - RUN: cmd_ready=0. The issue counter issues one read per cycle while issued<len and credit exists.
  - Return to IDLE on the cycle the last word handshakes (out_valid&&out_ready&&out_last). busy and cmd_ready update on the next cycle.
- Address wrap: the next address after RAM_DEPTH-1 is 0. A start address >= RAM_DEPTH is treated as 0.
- Buffering and credit:
  - Read data enters an output FIFO of depth RD_LAT+2.
  - A read issues only if (FIFO occupancy + reads in flight) < RD_LAT+2.
  - This guarantees no overflow under arbitrary out_ready stalls.
- Output stage:
  - out_data/out_valid/out_last come from the FIFO head, registered.
  - While out_valid && !out_ready, out_data and out_last hold stable.
- Latency: cmd accepted at cycle T -> first read issued T+1 -> out_valid=1 at T+1+RD_LAT.
- Throughput: with out_ready held high, one word per cycle, no bubbles.
- out_last is 1 only on word number len (1-based) of the burst.
- Arithmetic: the issue counter and the delivered counter are LEN_W bits wide, unsigned, and never wrap within a burst.

Test Plan:
- Byte-enable write: write 0x1122334455667788 at addr 5 with wrbe=0xFF, then 0xAAAA...AA with wrbe=0x0F. Burst(5,1) -> out_data=0x11223344AAAAAAAA, out_last=1.
- Full-rate burst: fill addr 0..15 with value=addr, RD_LAT=2, out_ready=1, cmd at T. Burst(0,16) -> out_valid first at T+3; words 0..15 on consecutive cycles; out_last on word 15; cmd_ready returns 1 on the cycle after the last handshake.
- Backpressure: burst(0,16) with out_ready toggling pseudo-randomly (≈30% low). Check: all 16 words in order, no loss or duplication, out_data stable while stalled, FIFO never overflows (assertion).
- Wrap and len=0: burst(RAM_DEPTH-2,4) -> data from addrs D-2, D-1, 0, 1. cmd_len=0 -> accepted, no out_valid, busy stays 0.
- Collision: during a burst, write new data to the exact address being issued that cycle -> streamed word is the old value; a later burst reads the new value.
- Reset mid-burst: assert rst for 1 cycle at word 7 of 16. Next cycle: out_valid=0, busy=0. Cycle after: cmd_ready=1. A new burst(0,4) returns correct words 0..3 with no stale data.

Source files
------------

// File: rtl/uram_wght_stream_if.sv
// Write port, burst command and streamed-output signals of the URAM weight streamer.
// The slave modport is the streamer; the master modport is the writer/consumer side.
interface uram_wght_stream_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LEN_W  = 16
);
  logic                     wren;
  logic [ADDR_W-1:0]        wraddr;
  logic signed [DATA_W-1:0] wrdat;
  logic [DATA_W/8-1:0]      wrbe;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [LEN_W-1:0]         cmd_len;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     busy;

  modport slave (
    input  wren, wraddr, wrdat, wrbe, cmd_valid, cmd_addr, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output wren, wraddr, wrdat, wrbe, cmd_valid, cmd_addr, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/uram_wght_stream.sv
// URAM weight store with a byte-enabled write port and a credit-controlled burst read engine
// that streams contiguous words over valid/ready.
module uram_wght_stream #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned RAM_DEPTH = 10485,
  parameter int unsigned ADDR_W    = $clog2(RAM_DEPTH),
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned LEN_W     = 16
) (
  input logic               clk,
  input logic               rst,
  uram_wght_stream_if.slave bus
);

  localparam int unsigned NumBytes  = DATA_W / 8;
  localparam int unsigned FifoDepth = RD_LAT + 2;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam logic [ADDR_W:0]   DepthA = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LastA  = ADDR_W'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];
  logic [ADDR_W-1:0] addr_q, start_addr;
  logic [LEN_W-1:0]  len_q, issued_q;
  logic [RD_LAT-1:0] s_vld_q, s_last_q;
  logic [DATA_W-1:0] s_dat_q [RD_LAT];
  logic [DATA_W-1:0] fifo_dat_q [FifoDepth];
  logic [FifoDepth-1:0] fifo_last_q;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW:0]     used;
  logic cmd_hs, issue, issue_last, fifo_empty, tail_vld, push, pop_fifo, hs_last;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Memory array: byte-enabled write, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (bus.wren && ({1'b0, bus.wraddr} < DepthA)) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (bus.wrbe[b]) mem_q[bus.wraddr][8*b +: 8] <= bus.wrdat[8*b +: 8];
      end
    end
  end

  assign start_addr = ({1'b0, bus.cmd_addr} < DepthA) ? bus.cmd_addr : '0;
  assign cmd_hs     = bus.cmd_valid && bus.cmd_ready;
  assign fifo_empty = (cnt_q == '0);
  assign tail_vld   = s_vld_q[RD_LAT-1];
  // A word leaving the pipeline bypasses the FIFO only when it is consumed immediately.
  assign push       = tail_vld && !(fifo_empty && bus.out_ready);
  assign pop_fifo   = bus.out_valid && bus.out_ready && !fifo_empty;
  assign hs_last    = bus.out_valid && bus.out_ready && bus.out_last;

  // Credit: buffered words plus reads still in the pipeline must leave a free slot.
  always_comb begin
    used = {1'b0, cnt_q};
    for (int unsigned k = 0; k < RD_LAT; k++) used = used + {{CntW{1'b0}}, s_vld_q[k]};
    issue      = (state_q == StRun) && (issued_q < len_q) && (used < (CntW + 1)'(FifoDepth));
    issue_last = issue && (issued_q == len_q - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_hs && (bus.cmd_len != '0)) state_d = StRun;
      StRun:  if (hs_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == StIdle) && !rst;
    bus.busy      = (state_q == StRun);
    bus.out_valid = !rst && (!fifo_empty || tail_vld);
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (bus.out_valid) begin
      if (!fifo_empty) begin
        bus.out_data = fifo_dat_q[rd_ptr_q];
        bus.out_last = fifo_last_q[rd_ptr_q];
      end else begin
        bus.out_data = s_dat_q[RD_LAT-1];
        bus.out_last = s_last_q[RD_LAT-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      s_vld_q  <= '0;
      s_last_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (cmd_hs) begin
        addr_q   <= start_addr;
        len_q    <= bus.cmd_len;
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= (addr_q == LastA) ? '0 : addr_q + 1'b1;
        issued_q <= issued_q + 1'b1;
      end
      s_vld_q[0]  <= issue;
      s_last_q[0] <= issue_last;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        s_vld_q[k]  <= s_vld_q[k-1];
        s_last_q[k] <= s_last_q[k-1];
      end
      if (push)     wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_fifo) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop_fifo)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop_fifo) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Stage 0 is the array read register; read-first because the write lands via NBA.
  always_ff @(posedge clk) begin
    if (issue) s_dat_q[0] <= mem_q[addr_q];
    for (int unsigned k = 1; k < RD_LAT; k++) s_dat_q[k] <= s_dat_q[k-1];
    if (push) begin
      fifo_dat_q[wr_ptr_q]  <= s_dat_q[RD_LAT-1];
      fifo_last_q[wr_ptr_q] <= s_last_q[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_uram_wght_stream.sv
// Directed and randomized bench for uram_wght_stream against an array/queue reference model.
module tb_uram_wght_stream;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned RAM_DEPTH = 10485;
  localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH);
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned LEN_W     = 16;
  localparam int          D         = int'(RAM_DEPTH);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] ref_mem [RAM_DEPTH];

  always #5 clk = ~clk;

  uram_wght_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_if ();

  uram_wght_stream #(
    .DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      assert (int'(dut.cnt_q) <= int'(RD_LAT) + 2) else begin
        errors++;
        $error("FAIL fifo_overflow observed=%0d expected<=%0d", dut.cnt_q, RD_LAT + 2);
      end
    end
  end

  task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] be);
    bus_if.wren   = 1'b1;
    bus_if.wraddr = ADDR_W'(a);
    bus_if.wrdat  = d;
    bus_if.wrbe   = be;
    if (a < D) begin
      for (int b = 0; b < int'(DATA_W / 8); b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk); #1;
    bus_if.wren = 1'b0;
  endtask

  // coll_cyc>0: overwrite the address issued in cycle T+coll_cyc; abort_at>0: stop after that word.
  task automatic burst(input int a, input int len, input int stall_pct, input bit timing,
                       input int abort_at, input int coll_cyc, input logic [DATA_W-1:0] coll_dat);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] prev_d;
    logic prev_l;
    bit   stalled;
    bit   done;
    int   ad;
    int   idx;
    int   ca;
    stalled = 1'b0;
    done    = 1'b0;
    idx     = 0;
    prev_d  = '0;
    prev_l  = 1'b0;
    ad = (a >= D) ? 0 : a;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(ref_mem[ad]);
      ad = (ad == D - 1) ? 0 : ad + 1;
    end
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_addr  = ADDR_W'(a);
    bus_if.cmd_len   = LEN_W'(len);
    @(negedge clk);
    chk("cmd_ready_idle", 64'(bus_if.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      bus_if.out_ready = ($urandom_range(99) >= stall_pct);
      if (cyc == coll_cyc) begin
        ca = ((a >= D ? 0 : a) + cyc - 1) % D;
        bus_if.wren   = 1'b1;
        bus_if.wraddr = ADDR_W'(ca);
        bus_if.wrdat  = coll_dat;
        bus_if.wrbe   = '1;
        ref_mem[ca]   = coll_dat;
      end
      @(negedge clk);
      if (timing && cyc <= int'(RD_LAT) + 1)
        chk("first_valid_latency", 64'(bus_if.out_valid), 64'(cyc == int'(RD_LAT) + 1));
      if (stalled) begin
        chk("stall_hold_data", bus_if.out_data, prev_d);
        chk("stall_hold_last", 64'(bus_if.out_last), 64'(prev_l));
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        chk("word_data", bus_if.out_data, exp_q[idx]);
        chk("word_last", 64'(bus_if.out_last), 64'(idx == len - 1));
        if (timing) chk("no_bubble", 64'(cyc), 64'(int'(RD_LAT) + 1 + idx));
        idx++;
        if (idx == len) begin
          chk("busy_last_cycle", 64'(bus_if.busy), 64'd1);
          done = 1'b1;
        end
        if (idx == abort_at) done = 1'b1;
      end
      stalled = bus_if.out_valid && !bus_if.out_ready;
      prev_d  = bus_if.out_data;
      prev_l  = bus_if.out_last;
      @(posedge clk); #1;
      bus_if.wren = 1'b0;
    end
    if (!done) chk("burst_timeout_words", 64'(idx), 64'(len));
    if (idx == len) begin
      @(negedge clk);
      chk("busy_after", 64'(bus_if.busy), 64'd0);
      chk("cmd_ready_after", 64'(bus_if.cmd_ready), 64'd1);
      chk("out_valid_after", 64'(bus_if.out_valid), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus_if.wren      = 1'b0;
    bus_if.wraddr    = '0;
    bus_if.wrdat     = '0;
    bus_if.wrbe      = '0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_out_data", bus_if.out_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    @(posedge clk); #1;

    // Byte enables
    wr(5, 64'h1122334455667788, 8'hFF);
    wr(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    burst(5, 1, 0, 1'b1, 0, 0, '0);

    // Full-rate burst, then the same burst under backpressure
    for (int i = 0; i < 16; i++) wr(i, 64'(i), 8'hFF);
    burst(0, 16, 0, 1'b1, 0, 0, '0);
    burst(0, 16, 30, 1'b0, 0, 0, '0);

    // Address wrap and out-of-range start
    wr(D - 2, 64'hD2D2D2D2_00000001, 8'hFF);
    wr(D - 1, 64'hD1D1D1D1_00000002, 8'hFF);
    burst(D - 2, 4, 0, 1'b1, 0, 0, '0);
    burst(D + 5, 2, 0, 1'b1, 0, 0, '0);

    // Zero-length command
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    @(negedge clk);
    chk("len0_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_valid_busy", {62'd0, bus_if.out_valid, bus_if.busy}, 64'd0);
      @(posedge clk); #1;
    end

    // Read-first collision, then the new value is visible
    burst(0, 8, 0, 1'b1, 0, 4, 64'hDEADBEEF_CAFEF00D);
    burst(3, 1, 0, 1'b1, 0, 0, '0);

    // Random contents, random partial and dropped writes, random stalls
    for (int i = 100; i < 132; i++) wr(i, {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 20; i++)
      wr(int'($urandom_range(131, 100)), {$urandom, $urandom}, 8'($urandom_range(255)));
    for (int i = 0; i < 4; i++)
      wr(int'($urandom_range(16383, RAM_DEPTH)), {$urandom, $urandom}, 8'hFF);
    burst(100, 32, 30, 1'b0, 0, 0, '0);
    for (int i = 0; i < 3; i++)
      burst(int'($urandom_range(120, 100)), int'($urandom_range(12, 1)), 30, 1'b0, 0, 0, '0);

    // Reset in the middle of a burst
    burst(0, 16, 0, 1'b0, 7, 0, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("midrst_busy", 64'(bus_if.busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_cmd_ready_after", 64'(bus_if.cmd_ready), 64'd1);
    @(posedge clk); #1;
    burst(0, 4, 0, 1'b1, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
